// File: rtl/next_out_pkg.sv
// next_out_pkg: opcodes, owner/state encodings and packet builder for the outbound arbiter
package next_out_pkg;
    localparam logic [7:0] OP_POWER_ON = 8'hC0;
    localparam logic [7:0] OP_KEYBOARD = 8'hC5;
    localparam logic [7:0] OP_MOUSE    = 8'hC6;
    localparam logic [7:0] OP_MIC      = 8'hC7;
    typedef enum logic [1:0] {OWN_PO, OWN_KB, OWN_MIC} owner_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    function automatic logic [39:0] build_packet(owner_e own, logic is_mouse, logic [15:0] kb, logic [31:0] mic);
        return own == OWN_PO ? {OP_POWER_ON, 32'h0} :
               own == OWN_KB ? {is_mouse ? OP_MOUSE : OP_KEYBOARD, 16'h0, kb} : {OP_MIC, mic};
    endfunction
endpackage

// File: rtl/next_out_grant.sv
// next_out_grant: fixed-priority source selector with bounded mic bursts
module next_out_grant
    import next_out_pkg::*;
#(
    parameter int MIC_BURST = 4,
    parameter int BW        = 3
) (
    input  logic          po_pend,
    input  logic          kb_pend,
    input  logic          mic_pend,
    input  logic [BW-1:0] mic_burst,
    input  logic          last_mic,
    output logic          gnt_valid,
    output owner_e        gnt_owner
);
    logic mic_hold;
    // Power-on first; an unfinished mic burst keeps priority over keyboard
    always_comb begin
        mic_hold  = mic_pend && last_mic && (mic_burst < BW'(MIC_BURST));
        gnt_valid = po_pend || kb_pend || mic_pend;
        gnt_owner = po_pend ? OWN_PO : mic_hold ? OWN_MIC : kb_pend ? OWN_KB : OWN_MIC;
    end
endmodule

// File: rtl/next_out_arbiter.sv
// next_out_arbiter: latches one outbound packet at a time for the monitor sender and acks its source
module next_out_arbiter
    import next_out_pkg::*;
#(
    parameter int TIMEOUT   = 16383,
    parameter int TW        = 14,
    parameter int MIC_BURST = 4
) (
    input  logic        mon_clk,
    input  logic        hw_reset_n,
    input  logic        power_on_req,
    input  logic        kb_req,
    input  logic        kb_is_mouse,
    input  logic [15:0] kb_data,
    output logic        kb_ack,
    input  logic        mic_req,
    input  logic [31:0] mic_data,
    output logic        mic_ack,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_data_retrieved,
    output logic        drop_pulse,
    output logic [7:0]  drop_count
);
    localparam int BW = $clog2(MIC_BURST + 1);

    state_e         state_q, state_d;
    owner_e         owner_q, owner_d, gnt_owner;
    logic           po_pend_q, po_pend_d, last_mic_q, last_mic_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic [TW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [39:0]    data_q, data_d;
    logic           valid_q, valid_d, kb_ack_q, kb_ack_d, mic_ack_q, mic_ack_d, drop_q, drop_d;
    logic [7:0]     drop_count_q, drop_count_d;
    logic           gnt_valid, grant, retrieve, timeout, finish;

    next_out_grant #(.MIC_BURST(MIC_BURST), .BW(BW)) u_grant (
        .po_pend   (po_pend_q || power_on_req),
        .kb_pend   (kb_req),
        .mic_pend  (mic_req),
        .mic_burst (burst_q),
        .last_mic  (last_mic_q),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    // State register
    always_ff @(posedge mon_clk or negedge hw_reset_n) begin
        if (!hw_reset_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next state: grant leaves IDLE, retrieval or timeout ends BUSY, DONE lasts one cycle
    always_comb begin
        cnt_inc  = cnt_q + 1'b1;
        retrieve = state_q == BUSY && out_data_retrieved;
        timeout  = state_q == BUSY && !out_data_retrieved && cnt_inc == TW'(TIMEOUT);
        state_d  = state_q == IDLE ? (gnt_valid ? BUSY : IDLE) :
                   state_q == BUSY ? (retrieve || timeout ? DONE : BUSY) : IDLE;
    end

    // Outputs and bookkeeping: latch packet on grant, pulse owner's ack and drop on completion
    always_comb begin
        grant        = state_q == IDLE && gnt_valid;
        finish       = retrieve || timeout;
        valid_d      = grant || (state_q == BUSY && !finish);
        data_d       = grant ? build_packet(gnt_owner, kb_is_mouse, kb_data, mic_data) : data_q;
        owner_d      = grant ? gnt_owner : owner_q;
        cnt_d        = grant ? '0 : state_q == BUSY ? cnt_inc : cnt_q;
        kb_ack_d     = finish && owner_q == OWN_KB;
        mic_ack_d    = finish && owner_q == OWN_MIC;
        drop_d       = timeout;
        drop_count_d = timeout && drop_count_q != 8'hFF ? drop_count_q + 8'd1 : drop_count_q;
        po_pend_d    = power_on_req || (po_pend_q && !(state_q == DONE && owner_q == OWN_PO));
        last_mic_d   = grant ? gnt_owner == OWN_MIC : last_mic_q;
        burst_d      = state_q != IDLE ? burst_q :
                       !(grant && gnt_owner == OWN_MIC) ? '0 :
                       burst_q == BW'(MIC_BURST) ? burst_q : burst_q + 1'b1;
    end

    // Datapath registers
    always_ff @(posedge mon_clk or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            owner_q      <= OWN_PO;
            po_pend_q    <= 1'b0;
            last_mic_q   <= 1'b0;
            burst_q      <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            kb_ack_q     <= 1'b0;
            mic_ack_q    <= 1'b0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            owner_q      <= owner_d;
            po_pend_q    <= po_pend_d;
            last_mic_q   <= last_mic_d;
            burst_q      <= burst_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            kb_ack_q     <= kb_ack_d;
            mic_ack_q    <= mic_ack_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign kb_ack     = kb_ack_q;
    assign mic_ack    = mic_ack_q;
    assign drop_pulse = drop_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_next_out_arbiter.sv
// tb_next_out_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_next_out_arbiter;
    localparam int TO = 16;
    localparam int MB = 4;

    logic        mon_clk = 1'b0, hw_reset_n = 1'b0, power_on_req = 1'b0;
    logic        kb_req = 1'b0, kb_is_mouse = 1'b0, mic_req = 1'b0, out_data_retrieved = 1'b0;
    logic [15:0] kb_data = 16'h0;
    logic [31:0] mic_data = 32'h0;
    logic        kb_ack, mic_ack, out_valid, drop_pulse;
    logic [39:0] out_data;
    logic [7:0]  drop_count;
    int          errors = 0, checks = 0;

    always #5 mon_clk = ~mon_clk;

    next_out_arbiter #(.TIMEOUT(TO), .TW(5), .MIC_BURST(MB)) dut (
        .mon_clk(mon_clk), .hw_reset_n(hw_reset_n), .power_on_req(power_on_req),
        .kb_req(kb_req), .kb_is_mouse(kb_is_mouse), .kb_data(kb_data), .kb_ack(kb_ack),
        .mic_req(mic_req), .mic_data(mic_data), .mic_ack(mic_ack),
        .out_data(out_data), .out_valid(out_valid), .out_data_retrieved(out_data_retrieved),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mon_clk);
        #1;
    endtask

    // Directed-sequence observer state
    logic [39:0] pkts[$];
    int n_kb, n_mic, n_drop, n_vcyc, v_age;
    bit prev_v;

    task automatic clr();
        pkts.delete();
        n_kb = 0; n_mic = 0; n_drop = 0; n_vcyc = 0; v_age = 0; prev_v = 1'b0;
    endtask

    function automatic logic [39:0] pk(input int i);
        return i < pkts.size() ? pkts[i] : 40'hFF_FFFF_FFFF;
    endfunction

    // Behavioural reference model
    bit m_po, m_valid, m_done, m_last_mic, e_kb, e_mic, e_drop;
    int m_owner, m_age, m_burst, m_drops;
    logic [39:0] m_data;

    task automatic m_reset();
        m_po = 0; m_valid = 0; m_done = 0; m_last_mic = 0; e_kb = 0; e_mic = 0; e_drop = 0;
        m_owner = 0; m_age = 0; m_burst = 0; m_drops = 0; m_data = 40'h0;
    endtask

    task automatic m_step();
        bit po_now = m_po || power_on_req;
        bit clr_po = 1'b0;
        e_kb = 0; e_mic = 0; e_drop = 0;
        if (m_done) begin
            clr_po = (m_owner == 0);
            m_done = 0;
        end else if (m_valid) begin
            m_age++;
            if (out_data_retrieved || m_age == TO) begin
                e_drop = !out_data_retrieved;
                m_valid = 0; m_done = 1;
                e_kb = (m_owner == 1);
                e_mic = (m_owner == 2);
                if (e_drop && m_drops < 255) m_drops++;
            end
        end else if (po_now || kb_req || mic_req) begin
            if (po_now) m_owner = 0;
            else if (mic_req && m_last_mic && m_burst < MB) m_owner = 2;
            else if (kb_req) m_owner = 1;
            else m_owner = 2;
            m_valid = 1; m_age = 0;
            m_last_mic = (m_owner == 2);
            m_burst = m_owner == 2 ? (m_burst < MB ? m_burst + 1 : MB) : 0;
            if (m_owner == 0) m_data = {8'hC0, 32'h0};
            else if (m_owner == 1) m_data = {kb_is_mouse ? 8'hC6 : 8'hC5, 16'h0, kb_data};
            else m_data = {8'hC7, mic_data};
        end else begin
            m_burst = 0;
        end
        m_po = power_on_req || (m_po && !clr_po);
    endtask

    task automatic do_reset();
        hw_reset_n = 1'b0; power_on_req = 1'b0; kb_req = 1'b0; kb_is_mouse = 1'b0;
        mic_req = 1'b0; out_data_retrieved = 1'b0; kb_data = 16'h0; mic_data = 32'h0;
        repeat (2) @(posedge mon_clk);
        #1 hw_reset_n = 1'b1;
        m_reset();
        clr();
    endtask

    // Sender retrieves dly cycles into each packet (dly<0: never); sources drop req on ack
    task automatic run(input int cycles, input int dly, input bit mic_keep);
        for (int c = 0; c < cycles; c++) begin
            tick();
            power_on_req = 1'b0;
            if (out_valid && !prev_v) pkts.push_back(out_data);
            v_age = out_valid ? v_age + 1 : 0;
            out_data_retrieved = (dly >= 0) && out_valid && (v_age == dly);
            n_vcyc += int'(out_valid);
            n_drop += int'(drop_pulse);
            if (kb_ack) begin n_kb++; kb_req = 1'b0; end
            if (mic_ack) begin n_mic++; if (!mic_keep) mic_req = 1'b0; end
            prev_v = out_valid;
        end
    endtask

    typedef struct {
        logic [3:0]  in;
        logic [15:0] kd;
        logic [31:0] md;
        logic [2:0]  ex;
        logic [39:0] ed;
    } vec_t;
    vec_t tbl[17];

    initial begin
        // in = {kb_req, kb_is_mouse, mic_req, out_data_retrieved}; ex = {out_valid, kb_ack, mic_ack} next cycle
        tbl[0]  = '{4'b1000, 16'h1234, 32'h0, 3'b100, 40'hC5_0000_1234};
        tbl[1]  = '{4'b1000, 16'h1234, 32'h0, 3'b100, 40'hC5_0000_1234};
        tbl[2]  = '{4'b1000, 16'h1234, 32'h0, 3'b100, 40'hC5_0000_1234};
        tbl[3]  = '{4'b1000, 16'h1234, 32'h0, 3'b100, 40'hC5_0000_1234};
        tbl[4]  = '{4'b1000, 16'h1234, 32'h0, 3'b100, 40'hC5_0000_1234};
        tbl[5]  = '{4'b1001, 16'h1234, 32'h0, 3'b010, 40'h0};
        tbl[6]  = '{4'b0000, 16'h0,    32'h0, 3'b000, 40'h0};
        tbl[7]  = '{4'b1100, 16'hABCD, 32'h0, 3'b100, 40'hC6_0000_ABCD};
        tbl[8]  = '{4'b1101, 16'hABCD, 32'h0, 3'b010, 40'h0};
        tbl[9]  = '{4'b0001, 16'h0,    32'h0, 3'b000, 40'h0};
        tbl[10] = '{4'b0011, 16'h0, 32'hDEADBEEF, 3'b100, 40'hC7_DEAD_BEEF};
        tbl[11] = '{4'b0011, 16'h0, 32'hDEADBEEF, 3'b001, 40'h0};
        tbl[12] = '{4'b0000, 16'h0,    32'h0, 3'b000, 40'h0};
        tbl[13] = '{4'b0010, 16'h0, 32'h01234567, 3'b100, 40'hC7_0123_4567};
        tbl[14] = '{4'b0000, 16'h0,    32'h0, 3'b100, 40'hC7_0123_4567};
        tbl[15] = '{4'b0001, 16'h0,    32'h0, 3'b001, 40'h0};
        tbl[16] = '{4'b0000, 16'h0,    32'h0, 3'b000, 40'h0};

        do_reset();
        check("reset outputs", 64'({out_valid, kb_ack, mic_ack, drop_pulse, drop_count}), 64'(0));
        check("reset data", 64'(out_data), 64'(0));

        for (int i = 0; i < 17; i++) begin
            {kb_req, kb_is_mouse, mic_req, out_data_retrieved} = tbl[i].in;
            kb_data = tbl[i].kd;
            mic_data = tbl[i].md;
            tick();
            check($sformatf("vec%0d valid/acks", i), 64'({out_valid, kb_ack, mic_ack}), 64'(tbl[i].ex));
            if (tbl[i].ex[2]) check($sformatf("vec%0d data", i), 64'(out_data), 64'(tbl[i].ed));
        end

        // Priority: power-on, then keyboard, then mic
        do_reset();
        power_on_req = 1'b1; kb_req = 1'b1; kb_data = 16'h1111; mic_req = 1'b1; mic_data = 32'h2222_2222;
        run(30, 1, 1'b0);
        check("prio count", 64'(pkts.size()), 64'(3));
        check("prio pkt0", 64'(pk(0)), 64'(40'hC0_0000_0000));
        check("prio pkt1", 64'(pk(1)), 64'(40'hC5_0000_1111));
        check("prio pkt2", 64'(pk(2)), 64'(40'hC7_2222_2222));
        check("prio acks", 64'({n_kb[7:0], n_mic[7:0]}), 64'(16'h0101));

        // Mic burst of 4 while keyboard waits
        do_reset();
        mic_req = 1'b1; mic_data = 32'h1111_0000;
        run(1, 3, 1'b1);
        kb_req = 1'b1; kb_data = 16'h00AB;
        run(40, 3, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("burst mic%0d", i), 64'(pk(i)), 64'(40'hC7_1111_0000));
        check("burst kb", 64'(pk(4)), 64'(40'hC5_0000_00AB));
        check("burst resume", 64'(pk(5)), 64'(40'hC7_1111_0000));
        mic_req = 1'b0;

        // Timeout drop, then retrieval in the timeout cycle
        do_reset();
        mic_req = 1'b1; mic_data = 32'hCAFE_0001;
        run(30, -1, 1'b0);
        check("timeout valid cycles", 64'(n_vcyc), 64'(TO));
        check("timeout drops", 64'({n_drop[7:0], n_mic[7:0], drop_count}), 64'(24'h010101));
        clr();
        mic_req = 1'b1;
        run(25, TO, 1'b0);
        check("late retrieve no drop", 64'({n_drop[7:0], n_mic[7:0], drop_count}), 64'(24'h000101));

        // Power-on pulses merge while pending
        do_reset();
        power_on_req = 1'b1;
        run(3, 5, 1'b0);
        power_on_req = 1'b1;
        run(20, 5, 1'b0);
        check("po merge count", 64'(pkts.size()), 64'(1));
        check("po merge pkt", 64'(pk(0)), 64'(40'hC0_0000_0000));

        // Power-on pulse in the completion cycle yields a second packet
        do_reset();
        power_on_req = 1'b1;
        run(6, 5, 1'b0);
        power_on_req = 1'b1;
        run(20, 5, 1'b0);
        check("po at completion count", 64'(pkts.size()), 64'(2));

        // Asynchronous reset in BUSY
        do_reset();
        kb_req = 1'b1; kb_data = 16'h5555;
        run(3, -1, 1'b0);
        check("busy before reset", 64'(out_valid), 64'(1));
        #2 hw_reset_n = 1'b0;
        #1;
        check("async reset valid", 64'(out_valid), 64'(0));
        kb_req = 1'b0;
        #2 hw_reset_n = 1'b1;
        clr();
        run(5, 1, 1'b0);
        check("reset no ack", 64'({n_kb[7:0], n_vcyc[7:0], drop_count}), 64'(0));

        // drop_count saturation
        do_reset();
        mic_req = 1'b1; mic_data = 32'h5A5A_5A5A;
        run(5450, -1, 1'b1);
        check("sat drop_count", 64'(drop_count), 64'(255));
        check("sat drops >= 300", 64'(n_drop >= 300), 64'(1));
        check("sat ack per drop", 64'(n_mic), 64'(n_drop));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit slow;
            tick();
            m_step();
            check("rand ctl", 64'({out_valid, kb_ack, mic_ack, drop_pulse, drop_count}),
                  64'({m_valid, e_kb, e_mic, e_drop, m_drops[7:0]}));
            if (m_valid) check("rand data", 64'(out_data), 64'(m_data));
            power_on_req = ($urandom_range(0, 39) == 0);
            if (kb_ack) kb_req = 1'b0;
            else if (!kb_req && $urandom_range(0, 5) == 0) begin
                kb_req = 1'b1; kb_is_mouse = 1'($urandom); kb_data = 16'($urandom);
            end
            if (mic_ack) mic_req = 1'b0;
            else if (!mic_req && $urandom_range(0, 2) == 0) begin
                mic_req = 1'b1; mic_data = $urandom;
            end
            slow = ((c / 400) % 2) == 1;
            out_data_retrieved = ($urandom_range(0, slow ? 24 : 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/next_out_arbiter.md
Name: next_out_arbiter

Overview:
- Sequences the single monitor-bound serial sender between three sources of outbound packets: the delayed power-on reply, keyboard/mouse events, and microphone samples.
- Latches one 40-bit packet at a time, holds it until the sender retrieves it, then acknowledges the winning source.
- Enforces a fixed priority, a bounded microphone burst and a retrieval timeout.
- Lives in the mon_clk domain, between the keyboard/mic sources and the sender.

Parameters:
- TIMEOUT, 16383: cycles out_valid may stay high without out_data_retrieved before the packet is dropped.
- TW, 14: width of the timeout counter; must satisfy TIMEOUT < 2^TW.
- MIC_BURST, 4: maximum consecutive mic grants while kb_req is pending.

Ports:
- mon_clk  in  1  clock; all logic on rising edge.
- hw_reset_n  in  1  asynchronous, active-low reset.
- power_on_req  in  1  one-cycle pulse requesting a power-on reply packet.
- kb_req  in  1  level; keyboard/mouse event pending; data held stable until kb_ack.
- kb_is_mouse  in  1  selects the mouse opcode.
- kb_data  in  16  key or mouse payload.
- kb_ack  out  1  one-cycle pulse: keyboard packet retrieved or dropped.
- mic_req  in  1  level; mic sample pending.
- mic_data  in  32  mic sample payload.
- mic_ack  out  1  one-cycle pulse: mic packet retrieved or dropped.
- out_data  out  40  packet to sender: {opcode[7:0], payload[31:0]}.
- out_valid  out  1  packet presented to sender.
- out_data_retrieved  in  1  one-cycle pulse from sender: packet taken.
- drop_pulse  out  1  one-cycle pulse on timeout drop.
- drop_count  out  8  saturating count of drops.

Behaviour:
- Reset values: every output, all pending flags, the burst counter and the timeout counter are 0; the state machine is in IDLE.
- Packet format (constants in the package):
  - POWER_ON: {8'hC0, 32'h0}
  - KEYBOARD: {8'hC5, 16'h0, kb_data}
  - MOUSE: {8'hC6, 16'h0, kb_data}
  - MIC: {8'hC7, mic_data}
- po_pend:
  - Set by power_on_req; a pulse arriving while already pending merges into it.
  - Cleared only when a power-on packet completes.
  - A pulse in the same cycle as completion leaves it set.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Grant order: po_pend first; then kb_req; then mic_req.
  - Exception: if mic_burst < MIC_BURST and the last grant was mic, mic wins over kb, so a mic stream is not broken until the burst is exhausted.
  - If mic_burst == MIC_BURST and kb_req is high, kb wins.
  - On grant: register out_data, set out_valid, record the owner, clear the timeout counter, go to BUSY.
  - Latency: request sampled in cycle N gives out_valid high in cycle N+1.
- BUSY:
  - out_valid and out_data are held constant.
  - out_data_retrieved -> DONE.
  - Otherwise the counter increments; on reaching TIMEOUT: drop_pulse, drop_count += 1 (saturating at 255), go to DONE.
  - Retrieval and timeout in the same cycle: retrieval wins, no drop.
- DONE (one cycle):
  - out_valid = 0.
  - Pulse the owner's ack (kb_ack or mic_ack), or clear po_pend if the owner is power-on.
  - mic_burst: increments on a mic grant (saturating at MIC_BURST); clears on a kb grant, a power-on grant, or an idle cycle with no mic_req.
  - Return to IDLE.
  - Back-to-back throughput: one packet per (retrieval latency + 2) cycles.
- Boundary conditions:
  - out_data_retrieved outside BUSY is ignored.
  - A source deasserting req after grant does not abort; its packet completes and the ack still pulses.
  - A new req from the same source is eligible in the IDLE cycle after its ack.
  - Asynchronous reset mid-packet drops the packet silently, with no ack.

Decomposition:
- Package next_out_pkg: opcode constants (OP_POWER_ON, OP_KEYBOARD, OP_MOUSE, OP_MIC), the owner enum (OWN_PO, OWN_KB, OWN_MIC) and the state enum.
- One natural sub-module, next_out_grant: the combinational priority/burst selector, taking the pending vector and burst state and returning the owner.

Test Plan:
- Single keyboard event: kb_req=1, kb_is_mouse=0, kb_data=16'h1234 at cycle 0; retrieved at cycle 5 -> out_data=40'hC5_0000_1234 and out_valid high in cycles 1–5; kb_ack pulse in cycle 6.
- Priority: power_on_req pulse together with kb_req and mic_req -> grant order is 40'hC0_0000_0000, then keyboard, then mic; exactly one ack each.
- Mic burst: mic_req held high; kb_req raised after the first mic grant; retrieval 2 cycles after each out_valid -> exactly 4 mic packets, then the keyboard packet, then mic resumes.
- Timeout: TIMEOUT=16 and no retrieval -> out_valid high for 16 cycles, then drop_pulse and mic_ack; drop_count=1. Retrieval in the timeout cycle -> no drop.
- Robustness:
  - Power-on pulses at cycles 0 and 3 -> a single C0 packet.
  - hw_reset_n low in BUSY -> out_valid=0 immediately, no ack, drop_count=0.
- Saturation: 300 forced timeouts -> drop_count=255.
